// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline boundary. Captures the ALU result, store data, destination
// index and control bits for the MEM stage, owns the architectural NZCV flag
// register, and resolves conditional branches (B.cond, CBZ, CBNZ) in EX so the
// decision arrives in MEM as mem_branch_taken.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   stall               hold every register (MEM not ready)
//   flush               replace the incoming instruction with a bubble
//   valid_in            EX holds a real instruction
//   alu_result          ALU output (WIDTH)
//   alu_zero/overflow/carryOut/negative   ALU flags for alu_result
//   set_flags           instruction writes NZCV (ADDS/SUBS/ANDS)
//   is_bcond/is_cbz/is_cbnz, cond          branch kind and B.cond code
//   store_data          register value for STUR (WIDTH)
//   rd                  destination register (REG_BITS)
//   reg_write/mem_read/mem_write           EX control bits
//   mem_*               registered copies for the MEM stage
//   mem_branch_taken    registered branch decision
//   flag_n/z/c/v        architectural flag register
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero,
  input  logic                alu_overflow,
  input  logic                alu_carryOut,
  input  logic                alu_negative,
  input  logic                set_flags,
  input  logic                is_bcond,
  input  logic                is_cbz,
  input  logic                is_cbnz,
  input  logic [3:0]          cond,
  input  logic [WIDTH-1:0]    store_data,
  input  logic [REG_BITS-1:0] rd,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_valid,
  output logic [WIDTH-1:0]    mem_alu_result,
  output logic [WIDTH-1:0]    mem_store_data,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                mem_branch_taken,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_v
);

  logic cond_true;
  logic branch_taken;
  logic load_bubble;
  logic load_insn;
  logic flags_we;

  // B.cond reads the registered flags, never this cycle's ALU flags. A
  // flag-setting op one cycle ahead has already been written by then, so no
  // bypass path is needed.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = !flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = !flag_v;
      4'b1000: cond_true = flag_c & !flag_z;
      4'b1001: cond_true = !(flag_c & !flag_z);
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = !flag_z & (flag_n == flag_v);
      4'b1101: cond_true = !(!flag_z & (flag_n == flag_v));
      default: cond_true = 1'b1;
    endcase
  end

  // CBZ/CBNZ: the ALU passes the tested register through, so alu_zero is
  // the register-is-zero test.
  always_comb begin
    branch_taken = 1'b0;
    if (is_cbz)
      branch_taken = alu_zero;
    else if (is_cbnz)
      branch_taken = !alu_zero;
    else if (is_bcond)
      branch_taken = cond_true;
  end

  // Flush beats stall; an empty EX slot with no stall is also a bubble.
  assign load_bubble = flush | (!stall & !valid_in);
  assign load_insn   = !flush & !stall & valid_in;
  assign flags_we    = load_insn & set_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid        <= 1'b0;
      mem_alu_result   <= '0;
      mem_store_data   <= '0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      mem_mem_read     <= 1'b0;
      mem_mem_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
    end else if (load_bubble) begin
      mem_valid        <= 1'b0;
      mem_alu_result   <= '0;
      mem_store_data   <= '0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      mem_mem_read     <= 1'b0;
      mem_mem_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
    end else if (load_insn) begin
      mem_valid        <= 1'b1;
      mem_alu_result   <= alu_result;
      mem_store_data   <= store_data;
      mem_rd           <= rd;
      mem_reg_write    <= reg_write;
      mem_mem_read     <= mem_read;
      mem_mem_write    <= mem_write;
      mem_branch_taken <= branch_taken;
    end
  end

  // Logical flag-setting ops clear C and V because the ALU drives those
  // flags low for them; nothing special is needed here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (flags_we) begin
      flag_n <= alu_negative;
      flag_z <= alu_zero;
      flag_c <= alu_carryOut;
      flag_v <= alu_overflow;
    end
  end

endmodule
